// File: rtl/tile_fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// tile_fetch_sequencer_if
//   Bundles the control, configuration and BRAM-read signals of the tile fetch
//   sequencer so the controller side and the sequencer share one port.
//
//   Control   : start, abort, stall          (controller -> sequencer)
//   Config    : cfg_mode, cfg_base_addr,
//               cfg_fetches_per_tile,
//               cfg_num_tiles                (controller -> sequencer)
//   BRAM side : bram_addr, bram_en           (sequencer -> BRAM port)
//   Status    : rd_valid, rd_last, tile_idx,
//               tile_done, all_done,
//               cfg_err, busy                (sequencer -> controller)
//
//   modport slave  : the sequencer view
//   modport master : the controller / driver view
// -----------------------------------------------------------------------------
interface tile_fetch_sequencer_if #(
   parameter int ADDR_WIDTH     = 11,
   parameter int MAX_FETCHES    = 16,
   parameter int TILE_CNT_WIDTH = 9
);
   localparam int FPT_WIDTH = $clog2(MAX_FETCHES + 1);

   logic                      start;
   logic                      abort;
   logic                      stall;
   logic                      cfg_mode;
   logic [ADDR_WIDTH-1:0]     cfg_base_addr;
   logic [FPT_WIDTH-1:0]      cfg_fetches_per_tile;
   logic [TILE_CNT_WIDTH-1:0] cfg_num_tiles;

   logic [ADDR_WIDTH-1:0]     bram_addr;
   logic                      bram_en;
   logic                      rd_valid;
   logic                      rd_last;
   logic [TILE_CNT_WIDTH-1:0] tile_idx;
   logic                      tile_done;
   logic                      all_done;
   logic                      cfg_err;
   logic                      busy;

   modport slave (
      input  start, abort, stall, cfg_mode, cfg_base_addr,
             cfg_fetches_per_tile, cfg_num_tiles,
      output bram_addr, bram_en, rd_valid, rd_last, tile_idx,
             tile_done, all_done, cfg_err, busy
   );

   modport master (
      output start, abort, stall, cfg_mode, cfg_base_addr,
             cfg_fetches_per_tile, cfg_num_tiles,
      input  bram_addr, bram_en, rd_valid, rd_last, tile_idx,
             tile_done, all_done, cfg_err, busy
   );
endinterface

// File: rtl/tile_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tile_fetch_sequencer
//   Issues BRAM read addresses for a run of tiles starting at a runtime base
//   address. Tiles are contiguous in memory (tile t starts at base + t*fpt).
//   Step mode issues one tile per start; auto mode runs all tiles back-to-back
//   with no gap cycle. rd_valid / rd_last are bram_en / last-of-tile delayed by
//   RD_LATENCY cycles so they line up with the BRAM read data.
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : tile_fetch_sequencer_if.slave (control, config, BRAM and status)
// -----------------------------------------------------------------------------
module tile_fetch_sequencer #(
   parameter int ADDR_WIDTH     = 11,
   parameter int MAX_FETCHES    = 16,
   parameter int TILE_CNT_WIDTH = 9,
   parameter int RD_LATENCY     = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   tile_fetch_sequencer_if.slave bus
);
   localparam int FPT_WIDTH = $clog2(MAX_FETCHES + 1);
   localparam logic [FPT_WIDTH-1:0]      FPT_ONE  = FPT_WIDTH'(1);
   localparam logic [FPT_WIDTH-1:0]      FPT_MAX  = FPT_WIDTH'(MAX_FETCHES);
   localparam logic [TILE_CNT_WIDTH-1:0] TILE_ONE = TILE_CNT_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0]     ADDR_ONE = ADDR_WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                    state, state_nxt;
   logic [ADDR_WIDTH-1:0]     ptr;
   logic [FPT_WIDTH-1:0]      offset;
   logic [FPT_WIDTH-1:0]      fpt_q;
   logic [TILE_CNT_WIDTH-1:0] tile_idx;
   logic [TILE_CNT_WIDTH-1:0] ntiles_q;
   logic                      mode_q;
   logic                      tile_done_q;
   logic                      all_done_q;
   logic                      cfg_err_q;
   logic [RD_LATENCY-1:0]     vld_p;
   logic [RD_LATENCY-1:0]     last_p;

   logic issue;
   logic issue_last;
   logic final_tile;
   logic cfg_bad;
   logic accept_new;

   assign issue_last = (offset == (fpt_q - FPT_ONE));
   assign final_tile = (tile_idx == (ntiles_q - TILE_ONE));
   assign cfg_bad    = (bus.cfg_fetches_per_tile == '0)
                    || (bus.cfg_fetches_per_tile > FPT_MAX)
                    || (bus.cfg_num_tiles == '0);

   // Next-state and issue decode. Abort overrides every other input, so no
   // issue or config acceptance can happen in an abort cycle.
   always_comb begin
      state_nxt  = state;
      issue      = 1'b0;
      accept_new = 1'b0;
      if (bus.abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (tile_idx != '0) begin
                     // step-mode continuation: latched config and pointer kept
                     state_nxt = FETCH;
                  end else begin
                     accept_new = 1'b1;
                     if (!cfg_bad) state_nxt = FETCH;
                  end
               end
            end
            FETCH: begin
               if (!bus.stall) begin
                  issue = 1'b1;
                  if (issue_last && (final_tile || !mode_q)) state_nxt = DONE;
               end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         ptr         <= '0;
         offset      <= '0;
         tile_idx    <= '0;
         mode_q      <= 1'b0;
         fpt_q       <= '0;
         ntiles_q    <= '0;
         tile_done_q <= 1'b0;
         all_done_q  <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         state       <= state_nxt;
         tile_done_q <= 1'b0;
         all_done_q  <= 1'b0;
         cfg_err_q   <= 1'b0;
         if (bus.abort) begin
            offset   <= '0;
            tile_idx <= '0;
         end else if (accept_new) begin
            // config is latched even when rejected; the next tile-0 start
            // relatches it anyway
            mode_q    <= bus.cfg_mode;
            fpt_q     <= bus.cfg_fetches_per_tile;
            ntiles_q  <= bus.cfg_num_tiles;
            cfg_err_q <= cfg_bad;
            if (!cfg_bad) begin
               ptr    <= bus.cfg_base_addr;
               offset <= '0;
            end
         end else if (issue) begin
            ptr <= ptr + ADDR_ONE;
            if (issue_last) begin
               offset      <= '0;
               tile_done_q <= 1'b1;
               if (final_tile) begin
                  tile_idx   <= '0;
                  all_done_q <= 1'b1;
               end else begin
                  tile_idx <= tile_idx + TILE_ONE;
               end
            end else begin
               offset <= offset + FPT_ONE;
            end
         end
      end
   end

   // Issue -> read-data alignment: stage i holds the strobe issued i+1 cycles ago
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p  <= '0;
         last_p <= '0;
      end else if (bus.abort) begin
         vld_p  <= '0;
         last_p <= '0;
      end else begin
         vld_p[0]  <= issue;
         last_p[0] <= issue && issue_last;
         for (int i = 1; i < RD_LATENCY; i++) begin
            vld_p[i]  <= vld_p[i-1];
            last_p[i] <= last_p[i-1];
         end
      end
   end

   assign bus.bram_addr = ptr;
   assign bus.bram_en   = issue;
   assign bus.rd_valid  = vld_p[RD_LATENCY-1];
   assign bus.rd_last   = last_p[RD_LATENCY-1];
   assign bus.tile_idx  = tile_idx;
   assign bus.tile_done = tile_done_q;
   assign bus.all_done  = all_done_q;
   assign bus.cfg_err   = cfg_err_q;
   assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_tile_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tile_fetch_sequencer
//   Scoreboard bench: directed stimulus pushes hand-computed expected reads
//   (address + last flag), tile completions and config errors into queues; a
//   monitor on the falling clock edge pops and compares whenever the DUT
//   presents bram_en, rd_valid, tile_done/all_done or cfg_err.
// -----------------------------------------------------------------------------
module tb_tile_fetch_sequencer;
   localparam int AW = 11;
   localparam int MF = 16;
   localparam int TW = 9;
   localparam int RL = 2;
   localparam int FW = $clog2(MF + 1);

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   tile_fetch_sequencer_if #(.ADDR_WIDTH(AW), .MAX_FETCHES(MF), .TILE_CNT_WIDTH(TW)) bus();

   tile_fetch_sequencer #(
      .ADDR_WIDTH(AW), .MAX_FETCHES(MF), .TILE_CNT_WIDTH(TW), .RD_LATENCY(RL)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct { logic [AW-1:0] addr; logic last; } iss_t;
   typedef struct { int cyc; logic last; } fl_t;
   typedef struct { logic all; logic [TW-1:0] idx; } td_t;

   iss_t exp_iss[$];
   fl_t  inflight[$];
   td_t  exp_td[$];
   int   exp_cerr = 0;
   int   n_cmp    = 0;
   int   n_err    = 0;
   int   cyc      = 0;

   function automatic void chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   // ---------------- monitor ----------------
   initial begin : monitor
      iss_t e;
      fl_t  f;
      td_t  t;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst_n) begin
            if (bus.rd_valid) begin
               if (inflight.size() == 0) chk("rd_valid_spurious", int'(bus.rd_valid), 0);
               else begin
                  f = inflight.pop_front();
                  chk("rd_latency", cyc - f.cyc, RL);
                  chk("rd_last", int'(bus.rd_last), int'(f.last));
               end
            end else if (bus.rd_last) begin
               chk("rd_last_without_valid", int'(bus.rd_last), 0);
            end
            if (bus.bram_en) begin
               if (exp_iss.size() == 0) chk("bram_en_spurious", int'(bus.bram_en), 0);
               else begin
                  e = exp_iss.pop_front();
                  chk("bram_addr", int'(bus.bram_addr), int'(e.addr));
                  inflight.push_back('{cyc, e.last});
               end
            end
            if (bus.tile_done || bus.all_done) begin
               if (exp_td.size() == 0) chk("done_spurious", int'({bus.tile_done, bus.all_done}), 0);
               else begin
                  t = exp_td.pop_front();
                  chk("tile_done", int'(bus.tile_done), 1);
                  chk("all_done", int'(bus.all_done), int'(t.all));
                  chk("tile_idx_at_done", int'(bus.tile_idx), int'(t.idx));
               end
            end
            if (bus.cfg_err) begin
               if (exp_cerr == 0) chk("cfg_err_spurious", int'(bus.cfg_err), 0);
               else begin
                  exp_cerr--;
                  chk("cfg_err_busy", int'(bus.busy), 0);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic set_cfg(input logic mode, input int base, input int fpt, input int tiles);
      bus.cfg_mode             = mode;
      bus.cfg_base_addr        = AW'(base);
      bus.cfg_fetches_per_tile = FW'(fpt);
      bus.cfg_num_tiles        = TW'(tiles);
   endtask

   task automatic push_addr(input int a, input logic last);
      logic [AW-1:0] av;
      av = AW'(a);
      exp_iss.push_back('{av, last});
   endtask

   // one tile of fpt reads from 'first' (wrapping), then its completion event
   task automatic push_tile(input int first, input int fpt, input logic all, input int idx);
      logic [TW-1:0] iv;
      for (int k = 0; k < fpt; k++) push_addr(first + k, (k == fpt - 1));
      iv = TW'(idx);
      exp_td.push_back('{all, iv});
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (bus.busy && n < budget) begin
         tick();
         n++;
      end
      if (bus.busy) chk("wait_idle_timeout", int'(bus.busy), 0);
      repeat (RL + 2) tick();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_bram_addr"}, int'(bus.bram_addr), 0);
      chk({tag, "_bram_en"},   int'(bus.bram_en),   0);
      chk({tag, "_rd_valid"},  int'(bus.rd_valid),  0);
      chk({tag, "_rd_last"},   int'(bus.rd_last),   0);
      chk({tag, "_tile_idx"},  int'(bus.tile_idx),  0);
      chk({tag, "_tile_done"}, int'(bus.tile_done), 0);
      chk({tag, "_all_done"},  int'(bus.all_done),  0);
      chk({tag, "_cfg_err"},   int'(bus.cfg_err),   0);
      chk({tag, "_busy"},      int'(bus.busy),      0);
   endtask

   // ---------------- directed tests ----------------
   initial begin : stimulus
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.stall = 1'b0;
      set_cfg(1'b0, 0, 1, 1);
      #2 rst_n = 1'b0;
      #21;
      check_zero("reset");
      tick();
      rst_n = 1'b1;
      tick();

      // 1: step mode, three starts; cfg changes after tile 0 must be ignored
      set_cfg(1'b0, 'h010, 4, 3);
      push_tile('h010, 4, 1'b0, 1);
      pulse_start();
      wait_idle(50);
      chk("t1_idx_after_tile0", int'(bus.tile_idx), 1);
      set_cfg(1'b1, 'h300, 1, 1);
      push_tile('h014, 4, 1'b0, 2);
      pulse_start();
      wait_idle(50);
      chk("t1_idx_after_tile1", int'(bus.tile_idx), 2);
      push_tile('h018, 4, 1'b1, 0);
      pulse_start();
      wait_idle(50);
      chk("t1_idx_after_tile2", int'(bus.tile_idx), 0);

      // 2: auto mode, 4 tiles of 2, no gaps
      set_cfg(1'b1, 'h000, 2, 4);
      push_tile('h000, 2, 1'b0, 1);
      push_tile('h002, 2, 1'b0, 2);
      push_tile('h004, 2, 1'b0, 3);
      push_tile('h006, 2, 1'b1, 0);
      pulse_start();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("t2_no_gap", int'(bus.bram_en), 1);
      end
      wait_idle(50);

      // 3: stall for 3 cycles after the 2nd issue
      set_cfg(1'b1, 'h100, 4, 1);
      push_tile('h100, 4, 1'b1, 0);
      pulse_start();
      tick();
      tick();
      bus.stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t3_stall_en", int'(bus.bram_en), 0);
         chk("t3_stall_addr", int'(bus.bram_addr), 'h102);
         tick();
      end
      bus.stall = 1'b0;
      wait_idle(50);

      // 4: rejected configurations
      set_cfg(1'b0, 'h040, 0, 2);
      exp_cerr++;
      pulse_start();
      chk("t4a_busy", int'(bus.busy), 0);
      chk("t4a_cfg_err", int'(bus.cfg_err), 1);
      tick();
      set_cfg(1'b0, 'h040, 4, 0);
      exp_cerr++;
      pulse_start();
      chk("t4b_busy", int'(bus.busy), 0);
      chk("t4b_cfg_err", int'(bus.cfg_err), 1);
      wait_idle(10);

      // 5: abort (with start) on the 3rd issue of tile 1
      set_cfg(1'b1, 'h020, 4, 3);
      push_tile('h020, 4, 1'b0, 1);
      push_addr('h024, 1'b0);
      push_addr('h025, 1'b0);
      pulse_start();
      repeat (6) tick();
      bus.abort = 1'b1;
      bus.start = 1'b1;
      tick();
      bus.abort = 1'b0;
      bus.start = 1'b0;
      chk("t5_busy", int'(bus.busy), 0);
      chk("t5_tile_idx", int'(bus.tile_idx), 0);
      chk("t5_rd_valid", int'(bus.rd_valid), 0);
      chk("t5_bram_en", int'(bus.bram_en), 0);
      chk("t5_reads_dropped", inflight.size(), 1);
      inflight.delete();
      tick();
      set_cfg(1'b1, 'h020, 2, 1);
      push_tile('h020, 2, 1'b1, 0);
      pulse_start();
      wait_idle(50);

      // 6: address wrap, then asynchronous reset mid-run
      set_cfg(1'b1, 'h7FE, 4, 1);
      push_tile('h7FE, 4, 1'b1, 0);
      pulse_start();
      wait_idle(50);
      push_addr('h7FE, 1'b0);
      push_addr('h7FF, 1'b0);
      pulse_start();
      tick();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_zero("t6_async_reset");
      chk("t6_reads_in_flight", inflight.size(), 2);
      inflight.delete();
      tick();
      rst_n = 1'b1;
      repeat (RL + 2) tick();

      chk("end_exp_iss_empty", exp_iss.size(), 0);
      chk("end_exp_td_empty", exp_td.size(), 0);
      chk("end_cfg_err_all_seen", exp_cerr, 0);
      chk("end_inflight_empty", inflight.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
